al_accel_ibuf_win: RTL and testbench
====================================

AL_ACCEL_IBUF_WIN -- requirements
Module: al_accel_ibuf_win

Interface
- REQ-001 SHALL have parameter KSIZE, default 3: window rows/columns and number of row banks.
- REQ-002 SHALL have parameter ROW_BYTES, default 6: bytes per row bank (ROW_BYTES >= KSIZE, ROW_BYTES >= DI_BYTES).
- REQ-003 SHALL have parameter DI_BYTES, default 4: bytes per input word.
- REQ-004 SHALL have the following ports, one per line (name, direction, width, meaning):
  - clk  in  1  sole clock, rising edge.
  - resetn  in  1  asynchronous active-low reset.
  - enb  in  1  global enable; 0 freezes all state.
  - ibuf_di  in  8*DI_BYTES  load word.
  - ibuf_init  in  8  fill byte for vacated positions.
  - ibuf_ld_wrn  in  1  1 = load cycle, 0 = move cycle.
  - ibuf_bank_sel  in  clog2(KSIZE+1)  target bank 1..KSIZE; 0 = none.
  - ibuf_wstrb  in  clog2(ROW_BYTES)  byte offset of the load within the bank.
  - ibuf_di_revert  in  1  byte-reverse the word before writing.
  - ibuf_shift  in  1  shift all banks by one byte.
  - ibuf_dir  in  1  0 = left, 1 = right.
  - ibuf_down  in  1  advance rows by one bank.
  - ibuf_win_o  out  8*KSIZE*KSIZE  KxK window; byte k*KSIZE+j = bank k byte j, bits [8n+7:8n].
  - ibuf_win_valid  out  1  window complete and in range.
  - ibuf_bank_vld  out  KSIZE  per-bank loaded flags.

Function
- REQ-005 Storage SHALL be KSIZE banks of ROW_BYTES bytes, byte 0 leftmost; bank k = ibuf_bank_sel k+1.
- REQ-006 Outputs SHALL be driven directly from registers, zero combinational input-to-output paths; effects of a cycle appear after its rising edge (1-cycle latency).
- REQ-007 enb=0 SHALL hold all registers regardless of other inputs.
- REQ-008 Priority per cycle SHALL be load > down > shift; one operation per cycle; lower ones ignored.
- REQ-009 Load (ld_wrn=1, bank_sel in 1..KSIZE): word byte n SHALL be written to bank byte wstrb+n (revert=0) or word byte DI_BYTES-1-n (revert=1); bytes landing at position >= ROW_BYTES SHALL be discarded; other bank bytes unchanged; bank_vld of target set.
- REQ-010 ld_wrn=1 with bank_sel=0 or >KSIZE SHALL be a complete no-op.
- REQ-011 Down (ld_wrn=0, down=1): bank k SHALL take bank k+1 for k<KSIZE-1, last bank SHALL fill with ibuf_init; bank_vld shifts likewise, last bit cleared.
- REQ-012 Shift left (ld_wrn=0, down=0, shift=1, dir=0): byte i <= byte i+1, byte ROW_BYTES-1 <= ibuf_init, all banks simultaneously; right (dir=1): byte i <= byte i-1, byte 0 <= ibuf_init.
- REQ-013 Shift counter shift_cnt SHALL clear on any valid load or down, increment on each shift, saturate at ROW_BYTES-KSIZE+1.
- REQ-014 ibuf_win_valid SHALL equal (&bank_vld) AND (shift_cnt <= ROW_BYTES-KSIZE).
- REQ-015 Simultaneous shift+down or load+shift SHALL follow REQ-008 with no partial effect of the lost operation.

Reset
- REQ-016 resetn=0 SHALL asynchronously clear all bank bytes, bank_vld and shift_cnt to 0; ibuf_win_o=0, ibuf_win_valid=0, ibuf_bank_vld=0.
- REQ-017 Reset mid-sequence SHALL abort all operations; first post-release edge behaves as from power-up.

Verification (defaults K=3, ROW_BYTES=6, DI_BYTES=4)
- REQ-018 Reset asserted mid-load -> win_o=0, valid=0, bank_vld=3'b000 immediately, before the next edge.
- REQ-019 Load 32'h44332211, bank 1, wstrb 0, revert 0 -> bank0 = 11,22,33,44,00,00; win row0 = 11,22,33; bank_vld=3'b001; revert=1 -> 44,33,22,11,00,00.
- REQ-020 Load 32'h44332211 bank 2 wstrb 4 -> bank1 bytes 4,5 = 11,22, 33/44 discarded, bytes 0-3 unchanged.
- REQ-021 All banks loaded, init=FF, four left shifts -> valid=1 after shifts 0-3, valid=0 after the 4th; byte 5 = FF after the first.
- REQ-022 down=1 on a full buffer -> bank0<=bank1, bank1<=bank2, bank2 = all FF, bank_vld=3'b011, valid=0; reload bank 3 -> valid=1, shift_cnt=0.
- REQ-023 enb=0 with ld_wrn=1 and shift=1 -> no register change; load+down in the same cycle -> only the load is applied.

Source files
------------

// File: rtl/al_accel_ibuf_win.sv
// Input buffer of KSIZE row banks feeding a KSIZE x KSIZE sliding window.
// Supports word loads, row advance (down) and byte shifts left/right.
module al_accel_ibuf_win #(
  parameter int unsigned KSIZE     = 3,
  parameter int unsigned ROW_BYTES = 6,
  parameter int unsigned DI_BYTES  = 4
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             enb,
  input  logic [8*DI_BYTES-1:0]            ibuf_di,
  input  logic [7:0]                       ibuf_init,
  input  logic                             ibuf_ld_wrn,
  input  logic [$clog2(KSIZE+1)-1:0]       ibuf_bank_sel,
  input  logic [$clog2(ROW_BYTES)-1:0]     ibuf_wstrb,
  input  logic                             ibuf_di_revert,
  input  logic                             ibuf_shift,
  input  logic                             ibuf_dir,
  input  logic                             ibuf_down,
  output logic [8*KSIZE*KSIZE-1:0]         ibuf_win_o,
  output logic                             ibuf_win_valid,
  output logic [KSIZE-1:0]                 ibuf_bank_vld
);

  localparam int unsigned BSW = $clog2(KSIZE+1);
  localparam int unsigned CW  = $clog2(ROW_BYTES-KSIZE+2);
  localparam logic [CW-1:0] CntSat  = CW'(ROW_BYTES-KSIZE+1);
  localparam logic [CW-1:0] CntLast = CW'(ROW_BYTES-KSIZE);

  logic [7:0]       r_bank     [KSIZE][ROW_BYTES];
  logic [7:0]       w_bank_nxt [KSIZE][ROW_BYTES];
  logic [KSIZE-1:0] r_vld, w_vld_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;

  always_comb begin
    w_bank_nxt = r_bank;
    w_vld_nxt  = r_vld;
    w_cnt_nxt  = r_cnt;
    if (ibuf_ld_wrn) begin
      // Unmatched bank_sel falls through every branch: a full no-op.
      for (int k = 0; k < KSIZE; k++) begin
        if (ibuf_bank_sel == BSW'(k+1)) begin
          for (int b = 0; b < ROW_BYTES; b++) begin
            for (int n = 0; n < DI_BYTES; n++) begin
              if (int'(ibuf_wstrb) + n == b) begin
                w_bank_nxt[k][b] = ibuf_di_revert ? ibuf_di[8*(DI_BYTES-1-n) +: 8]
                                                  : ibuf_di[8*n +: 8];
              end
            end
          end
          w_vld_nxt[k] = 1'b1;
          w_cnt_nxt    = '0;
        end
      end
    end else if (ibuf_down) begin
      for (int k = 0; k < KSIZE-1; k++) begin
        w_bank_nxt[k] = r_bank[k+1];
      end
      for (int b = 0; b < ROW_BYTES; b++) begin
        w_bank_nxt[KSIZE-1][b] = ibuf_init;
      end
      w_vld_nxt = {1'b0, r_vld[KSIZE-1:1]};
      w_cnt_nxt = '0;
    end else if (ibuf_shift) begin
      for (int k = 0; k < KSIZE; k++) begin
        if (!ibuf_dir) begin
          for (int b = 0; b < ROW_BYTES-1; b++) begin
            w_bank_nxt[k][b] = r_bank[k][b+1];
          end
          w_bank_nxt[k][ROW_BYTES-1] = ibuf_init;
        end else begin
          for (int b = 1; b < ROW_BYTES; b++) begin
            w_bank_nxt[k][b] = r_bank[k][b-1];
          end
          w_bank_nxt[k][0] = ibuf_init;
        end
      end
      w_cnt_nxt = (r_cnt == CntSat) ? CntSat : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < KSIZE; k++) begin
        for (int b = 0; b < ROW_BYTES; b++) begin
          r_bank[k][b] <= '0;
        end
      end
      r_vld <= '0;
      r_cnt <= '0;
    end else if (enb) begin
      r_bank <= w_bank_nxt;
      r_vld  <= w_vld_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Window is the leftmost KSIZE bytes of every bank.
  for (genvar k = 0; k < KSIZE; k++) begin : g_row
    for (genvar j = 0; j < KSIZE; j++) begin : g_col
      assign ibuf_win_o[8*(k*KSIZE+j) +: 8] = r_bank[k][j];
    end
  end

  assign ibuf_bank_vld  = r_vld;
  assign ibuf_win_valid = (&r_vld) && (r_cnt <= CntLast);

endmodule

// File: tb/tb_al_accel_ibuf_win.sv
// Randomized self-checking bench for al_accel_ibuf_win against a byte-array model.
module tb_al_accel_ibuf_win;
  localparam int K = 3;
  localparam int R = 6;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          enb;
  logic [31:0]   di;
  logic [7:0]    init;
  logic          ld;
  logic [1:0]    sel;
  logic [2:0]    wstrb;
  logic          rev;
  logic          shift;
  logic          dir;
  logic          down;
  logic [71:0]   win;
  logic          valid;
  logic [2:0]    bvld;

  int n_checks = 0;
  int n_errors = 0;

  byte unsigned m_bank [K][R];
  bit           m_vld  [K];
  int           m_cnt;

  al_accel_ibuf_win #(.KSIZE(K), .ROW_BYTES(R), .DI_BYTES(D)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enb            (enb),
    .ibuf_di        (di),
    .ibuf_init      (init),
    .ibuf_ld_wrn    (ld),
    .ibuf_bank_sel  (sel),
    .ibuf_wstrb     (wstrb),
    .ibuf_di_revert (rev),
    .ibuf_shift     (shift),
    .ibuf_dir       (dir),
    .ibuf_down      (down),
    .ibuf_win_o     (win),
    .ibuf_win_valid (valid),
    .ibuf_bank_vld  (bvld)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < K; k++) begin
      m_vld[k] = 1'b0;
      for (int b = 0; b < R; b++) m_bank[k][b] = 8'h00;
    end
    m_cnt = 0;
  endfunction

  // One enabled clock edge, applying the operation priority load > down > shift.
  function automatic void model_step();
    byte unsigned wb [D];
    byte unsigned tmp [K][R];
    if (!enb) return;
    for (int n = 0; n < D; n++) wb[n] = 8'((di >> (8*n)) & 32'hFF);
    tmp = m_bank;
    if (ld) begin
      if (sel >= 1 && int'(sel) <= K) begin
        for (int n = 0; n < D; n++) begin
          if (int'(wstrb) + n < R) tmp[sel-1][int'(wstrb)+n] = rev ? wb[D-1-n] : wb[n];
        end
        m_vld[sel-1] = 1'b1;
        m_cnt = 0;
      end
    end else if (down) begin
      for (int k = 0; k < K; k++) begin
        for (int b = 0; b < R; b++) tmp[k][b] = (k == K-1) ? init : m_bank[k+1][b];
        m_vld[k] = (k == K-1) ? 1'b0 : m_vld[k+1];
      end
      m_cnt = 0;
    end else if (shift) begin
      for (int k = 0; k < K; k++) begin
        for (int b = 0; b < R; b++) begin
          if (!dir) tmp[k][b] = (b == R-1) ? init : m_bank[k][b+1];
          else      tmp[k][b] = (b == 0)   ? init : m_bank[k][b-1];
        end
      end
      m_cnt = (m_cnt + 1 > R-K+1) ? R-K+1 : m_cnt + 1;
    end
    m_bank = tmp;
  endfunction

  function automatic logic [71:0] exp_win();
    logic [71:0] e = '0;
    for (int k = 0; k < K; k++)
      for (int j = 0; j < K; j++) e[8*(k*K+j) +: 8] = m_bank[k][j];
    return e;
  endfunction

  function automatic logic [2:0] exp_vld();
    logic [2:0] v;
    for (int k = 0; k < K; k++) v[k] = m_vld[k];
    return v;
  endfunction

  function automatic logic exp_valid();
    return (exp_vld() == 3'b111) && (m_cnt <= R-K);
  endfunction

  task automatic check_model(input string tag);
    check_val({tag, "_win"}, win, exp_win());
    check_val({tag, "_vld"}, bvld, exp_vld());
    check_val({tag, "_valid"}, valid, exp_valid());
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic idle();
    enb = 1'b1; ld = 1'b0; sel = 2'd0; wstrb = 3'd0; rev = 1'b0;
    shift = 1'b0; dir = 1'b0; down = 1'b0; di = '0; init = 8'h00;
  endtask

  task automatic load(input logic [1:0] s, input logic [2:0] w, input logic [31:0] d,
                      input logic r, input string tag);
    idle();
    ld = 1'b1; sel = s; wstrb = w; di = d; rev = r;
    step(tag);
  endtask

  logic [71:0] saved;

  initial begin
    idle();
    resetn = 1'b0;
    model_reset();
    #12;
    check_model("reset");
    @(negedge clk);
    resetn = 1'b1;

    load(2'd1, 3'd0, 32'h44332211, 1'b0, "ld_plain");
    check_val("ld_plain_row0", win[23:0], 24'h332211);
    check_val("ld_plain_bvld", bvld, 3'b001);
    load(2'd1, 3'd0, 32'h44332211, 1'b1, "ld_rev");
    check_val("ld_rev_row0", win[23:0], 24'h223344);
    load(2'd2, 3'd0, 32'hA5A6A7A8, 1'b0, "ld_b2");
    load(2'd2, 3'd4, 32'h44332211, 1'b0, "ld_edge");
    check_val("ld_edge_row1", win[47:24], 24'hA6A7A8);

    // Fill every bank fully, then walk the window off the right edge.
    for (int k = 1; k <= K; k++) begin
      load(2'(k), 3'd0, $urandom, 1'b0, "fill_lo");
      load(2'(k), 3'd2, $urandom, 1'b0, "fill_hi");
    end
    check_val("shift0_valid", valid, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      idle(); shift = 1'b1; init = 8'hFF;
      step("shl");
      check_val($sformatf("shift%0d_valid", i), valid, (i < 4) ? 1'b1 : 1'b0);
    end
    idle(); down = 1'b1; init = 8'hFF; shift = 1'b1;
    step("down");
    check_val("down_bvld", bvld, 3'b011);
    check_val("down_valid", valid, 1'b0);
    check_val("down_row2", win[71:48], 24'hFFFFFF);
    load(2'd3, 3'd0, 32'h0BADBEEF, 1'b0, "reload");
    check_val("reload_valid", valid, 1'b1);

    saved = exp_win();
    idle(); enb = 1'b0; ld = 1'b1; sel = 2'd1; shift = 1'b1; di = 32'h12345678;
    step("hold");
    check_val("hold_win", win, saved);
    idle(); ld = 1'b1; sel = 2'd2; down = 1'b1; di = 32'hCAFEF00D;
    step("ld_over_down");
    check_val("ld_over_down_bvld", bvld, 3'b111);
    idle(); ld = 1'b1; sel = 2'd0; down = 1'b1; shift = 1'b1;
    step("sel0_noop");

    // Asynchronous reset in the middle of a load cycle.
    idle(); ld = 1'b1; sel = 2'd1; di = 32'hDEADBEEF;
    #1;
    resetn = 1'b0;
    model_reset();
    #1;
    check_model("async_rst");
    @(negedge clk);
    idle();
    resetn = 1'b1;
    step("post_rst");

    for (int i = 0; i < 400; i++) begin
      enb   = ($urandom_range(0, 7) != 0);
      ld    = ($urandom_range(0, 2) == 0);
      sel   = 2'($urandom_range(0, 3));
      wstrb = 3'($urandom_range(0, 7));
      rev   = 1'($urandom);
      shift = 1'($urandom);
      dir   = 1'($urandom);
      down  = ($urandom_range(0, 5) == 0);
      di    = $urandom;
      init  = 8'($urandom);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
